// File: rtl/m10k_controller.sv
// On-chip word memory controller: zero-fill after reset, byte-enabled writes,
// fixed-latency reads with a readvalid strobe, and a sticky access-error flag.
//
// state | meaning
// INIT  | sweeping addresses 0..DEPTH-1 with zero words; requests ignored
// RUN   | accepting one read or write per cycle, no back-pressure
module m10k_controller #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int DEPTH        = 256,
   parameter int READ_LATENCY = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic [DATA_WIDTH-1:0]   writedata,
   output logic                    ready,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readvalid,
   output logic                    init_done,
   output logic                    error
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [READ_LATENCY-1:0] pipe_valid;
   logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

   logic in_range;
   logic rd_ok;
   logic wr_ok;
   logic bad_access;

   assign in_range   = ({1'b0, address} < LIMIT);
   // A read paired with a write is dropped; only the write proceeds.
   assign rd_ok      = ready && read && !write;
   assign wr_ok      = ready && write && in_range;
   assign bad_access = ready && ((read && write) || ((read || write) && !in_range));

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= INIT;
         cnt       <= '0;
         ready     <= 1'b0;
         init_done <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (cnt == LAST) begin
                  state     <= RUN;
                  ready     <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (bad_access) error <= 1'b1;
            end
            default: state <= INIT;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == INIT) begin
            mem[cnt[ADDR_WIDTH-1:0]] <= '0;
         end else if (wr_ok) begin
            for (int i = 0; i < BYTES; i++) begin
               if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
         end
      end
   end

   // Data travels zeroed unless it belongs to a valid in-range read.
   always_ff @(posedge clock) begin
      if (reset) begin
         pipe_valid <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
      end else begin
         pipe_valid[0] <= rd_ok;
         pipe_data[0]  <= (rd_ok && in_range) ? mem[address] : '0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   assign readvalid = pipe_valid[READ_LATENCY-1];
   assign readdata  = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_m10k_controller.sv
// Scoreboard bench for m10k_controller: driver pushes expected read results
// from a word-array model, a negedge monitor pops and compares them.
module tb_m10k_controller;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 200;
   localparam int LAT   = 2;
   localparam int INF   = 32'h7fffffff;

   logic          clock = 1'b0;
   logic          reset;
   logic          read;
   logic          write;
   logic [AW-1:0] address;
   logic [3:0]    byteenable;
   logic [DW-1:0] writedata;
   logic          ready;
   logic [DW-1:0] readdata;
   logic          readvalid;
   logic          init_done;
   logic          error;

   m10k_controller #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT)
   ) dut (
      .clock(clock), .reset(reset), .read(read), .write(write),
      .address(address), .byteenable(byteenable), .writedata(writedata),
      .ready(ready), .readdata(readdata), .readvalid(readvalid),
      .init_done(init_done), .error(error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] mm [DEPTH];
   int            cyc = 0;
   int            err_set_cyc = INF;
   bit            err_chk = 1'b0;
   bit            mon_en = 1'b0;
   int            vectors = 0;
   int            miscompares = 0;

   always @(posedge clock) cyc++;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         if (readvalid) begin
            if (q.size() == 0) begin
               chk("spurious_readvalid", 32'(readvalid), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("readdata", readdata, e.data);
               chk("readvalid_cycle", cyc, e.due);
            end
         end else begin
            chk("readdata_idle", readdata, 32'd0);
            if (q.size() != 0 && q[0].due < cyc) begin
               chk("missing_readvalid", 32'd0, 32'd1);
               void'(q.pop_front());
            end
         end
         if (err_chk) chk("error", 32'(error), 32'(err_set_cyc <= cyc));
      end
   end

   task automatic flag_err();
      if (err_set_cyc > cyc + 1) err_set_cyc = cyc + 1;
   endtask

   // Drives one request for the next clock edge and records what it should do.
   task automatic issue(bit rd, bit wr, int a, logic [3:0] be, logic [DW-1:0] d);
      exp_t e;
      @(posedge clock); #2;
      read = rd; write = wr; address = a[AW-1:0]; byteenable = be; writedata = d;
      chk("ready", 32'(ready), 32'd1);
      if (wr && a < DEPTH)
         for (int i = 0; i < 4; i++) if (be[i]) mm[a][8*i +: 8] = d[8*i +: 8];
      if (rd && wr) begin
         flag_err();
      end else if (rd) begin
         e.data = (a < DEPTH) ? mm[a] : '0;
         e.due  = cyc + LAT;
         q.push_back(e);
      end
      if ((rd || wr) && a >= DEPTH) flag_err();
   endtask

   task automatic do_reset();
      int n;
      @(posedge clock); #2;
      reset = 1'b1; read = 1'b0; write = 1'b0;
      q.delete();
      err_chk = 1'b0;
      err_set_cyc = INF;
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      @(posedge clock); #1;
      mon_en = 1'b1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_readvalid", 32'(readvalid), 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      #1;
      reset = 1'b0;
      // Requests during the sweep must be ignored, including this conflicting pair.
      read = 1'b1; write = 1'b1; address = 8'd5; byteenable = 4'hF; writedata = 32'hCAFEF00D;
      n = 0;
      while (n < DEPTH + 20) begin
         @(posedge clock); #1;
         n++;
         if (ready) break;
      end
      read = 1'b0; write = 1'b0;
      chk("init_cycles", n, DEPTH);
      chk("init_done", 32'(init_done), 32'd1);
      err_chk = 1'b1;
   endtask

   initial begin
      int a;
      int r;
      reset = 1'b1; read = 1'b0; write = 1'b0;
      address = '0; byteenable = '0; writedata = '0;
      repeat (3) @(posedge clock);
      do_reset();

      issue(1, 0, 8'h7F, 4'h0, 0);
      issue(1, 0, 8'h05, 4'h0, 0);
      issue(0, 0, 0, 4'h0, 0);

      issue(0, 1, 8'h10, 4'hF, 32'hDEADBEEF);
      issue(0, 1, 8'h10, 4'b0001, 32'h000000AA);
      issue(1, 0, 8'h10, 4'h0, 0);
      issue(0, 1, 8'h11, 4'h0, 32'hFFFFFFFF);
      issue(1, 0, 8'h11, 4'h0, 0);

      for (int i = 0; i < 8; i++) issue(0, 1, i, 4'hF, i + 1);
      for (int i = 0; i < 8; i++) issue(1, 0, i, 4'h0, 0);
      issue(0, 0, 0, 4'h0, 0);
      repeat (4) @(posedge clock);

      issue(0, 1, 8'hC8, 4'hF, 32'h55);
      issue(1, 0, 8'hC8, 4'h0, 0);
      issue(1, 0, 8'h00, 4'h0, 0);
      issue(1, 0, DEPTH - 1, 4'h0, 0);

      issue(1, 1, 8'h20, 4'hF, 32'h12345678);
      issue(0, 0, 0, 4'h0, 0);
      issue(1, 0, 8'h20, 4'h0, 0);

      issue(0, 1, 8'h10, 4'hF, 32'h0BADF00D);
      issue(1, 0, 8'h10, 4'h0, 0);
      do_reset();
      issue(1, 0, 8'h10, 4'h0, 0);
      issue(1, 0, 8'h05, 4'h0, 0);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         a = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, DEPTH - 1);
         if (r < 4)       issue(1, 0, a, 4'h0, 0);
         else if (r < 8)  issue(0, 1, a, 4'($urandom_range(0, 15)), $urandom);
         else if (r == 8) issue(1, 1, a, 4'($urandom_range(0, 15)), $urandom);
         else             issue(0, 0, 0, 4'h0, 0);
      end
      issue(0, 0, 0, 4'h0, 0);
      repeat (LAT + 4) @(posedge clock);
      #1;
      chk("queue_drained", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/m10k_controller.md
Name: m10k_controller

Overview:
- Parametrised on-chip memory controller. Successor to the fixed 256x32 M10K wrapper and fakemem test stub.
- Provides byte-enabled writes, configurable read latency with a readvalid strobe, and hardware zero-initialisation after reset.
- Bounds checking sets a sticky error flag.
- Sits between a tensor load/store engine and an inferred M10K array; presents a ready/valid-style request interface.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address bus width.
- DEPTH, 256, number of words implemented; 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 2, cycles from accepted read to readvalid; 1 to 4.

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  read request.
- write  input  1  write request.
- address  input  ADDR_WIDTH  word address.
- byteenable  input  DATA_WIDTH/8  per-byte write mask; bit i covers writedata[8i+7:8i].
- writedata  input  DATA_WIDTH  write data.
- ready  output  1  controller can accept a request this cycle.
- readdata  output  DATA_WIDTH  read result; valid only when readvalid=1.
- readvalid  output  1  one-cycle strobe per accepted read.
- init_done  output  1  zero-fill sweep complete.
- error  output  1  sticky; set on out-of-range access or read&write together.

Behaviour:
- Reset values: ready=0, readvalid=0, readdata=0, init_done=0, error=0. The read pipeline is flushed and the FSM enters INIT.
- FSM state INIT: a counter sweeps addresses 0..DEPTH-1, writing all-zero words, one word per cycle.
  - ready=0 throughout; requests presented during INIT are ignored.
  - When the counter reaches DEPTH-1, the next state is RUN. init_done=1 and ready=1 from the first RUN cycle, so ready rises exactly DEPTH cycles after the cycle in which reset is deasserted.
- FSM state RUN: ready=1 every cycle. There is no back-pressure; READ_LATENCY reads can be in flight.
- Request acceptance: accepted on a clock edge when ready=1 and (read|write)=1.
- Write:
  - Memory bytes with byteenable[i]=1 take the new value at the accepting edge; the other bytes are unchanged.
  - byteenable=0 is a legal no-op write.
- Read: data is sampled from the array after any write accepted on earlier edges (read-after-write at N+1 returns new data). readvalid and readdata are driven exactly READ_LATENCY cycles after the accepting edge.
- Pipelining: back-to-back reads give back-to-back readvalid pulses, in order, one per cycle.
- readdata forced to 0 when readvalid=0. This matches the existing stub contract.
- Simultaneous read and write:
  - The write executes.
  - The read is dropped; no readvalid is produced.
  - error is set.
- Out-of-range access (address >= DEPTH):
  - A write is ignored.
  - A read still produces readvalid with readdata=0.
  - Both cases set error.
- error clears only on reset.
- Reset mid-operation: on the reset edge, in-flight reads are discarded; no readvalid appears afterwards. Memory is re-zeroed by a fresh INIT sweep.
- Widths: the counter is ADDR_WIDTH+1 bits so DEPTH=2**ADDR_WIDTH terminates correctly. No arithmetic on data.

Test Plan:
1. Reset, then count cycles -> ready=0 for exactly 256 cycles, then ready=init_done=1. A read of address 0x7F returns 0x00000000 with readvalid at +2.
2. Write 0xDEADBEEF to 0x10 (be=4'hF), next cycle write 0x000000AA to 0x10 (be=4'b0001), then read 0x10 -> readdata=0xDEADBEAA, readvalid exactly 2 cycles after the read's accept edge.
3. Fill 0x00..0x07 with values 1..8, then issue 8 consecutive reads -> 8 consecutive readvalid pulses, data 1..8 in order, readdata=0 between/after.
4. With DEPTH=200: write 0x55 to 0xC8, then read 0xC8 -> readvalid with readdata=0, error=1 and remains 1. A subsequent read of 0x00 behaves normally.
5. Assert read=write=1 at address 0x20 with writedata 0x12345678 -> no readvalid, error=1; a later read of 0x20 returns 0x12345678.
6. Issue a read to 0x10 then assert reset on the next cycle -> no readvalid ever, ready=0 for 256 cycles, and 0x10 reads back as 0.
